// File: rtl/otp_stream_cipher_pkg.sv
// ----------------------------------------------------------------------------
// otp_pkg
// Shared definitions for the one-time-pad stream cipher:
//   - otp_state_e      : key-lifecycle state encoding (2 bits)
//   - OTP_DEFAULT_TAPS : maximal-length Fibonacci tap mask for an 8-bit LFSR
// ----------------------------------------------------------------------------
package otp_pkg;

  typedef enum logic [1:0] {
    NOKEY     = 2'd0,
    ACTIVE    = 2'd1,
    EXHAUSTED = 2'd2
  } otp_state_e;

  localparam logic [7:0] OTP_DEFAULT_TAPS = 8'hB8;

endpackage

// File: rtl/otp_stream_cipher_if.sv
// ----------------------------------------------------------------------------
// otp_stream_cipher_if
// Beat-stream interface of the cipher: an input channel (in_valid/in_ready/
// in_data) and an output channel (out_valid/out_ready/out_data).
//   master : the traffic source/sink around the cipher
//   slave  : the cipher itself
// Parameter M is the data beat width.
// ----------------------------------------------------------------------------
interface otp_stream_cipher_if #(
  parameter int M = 8
);
  logic         in_valid;
  logic         in_ready;
  logic [M-1:0] in_data;
  logic         out_valid;
  logic         out_ready;
  logic [M-1:0] out_data;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data
  );
endinterface

// File: rtl/otp_lfsr_step.sv
// ----------------------------------------------------------------------------
// otp_lfsr_step
// One combinational step of a Fibonacci LFSR: the feedback bit is the parity
// of the tapped bits and is shifted in at the LSB.
// Ports:
//   key_i      [N-1:0] current register value
//   key_next_o [N-1:0] value after one step
// ----------------------------------------------------------------------------
module otp_lfsr_step #(
  parameter int             N    = 8,
  parameter logic [N-1:0]   TAPS = N'(otp_pkg::OTP_DEFAULT_TAPS)
) (
  input  logic [N-1:0] key_i,
  output logic [N-1:0] key_next_o
);

  logic fb;

  assign fb         = ^(key_i & TAPS);
  assign key_next_o = {key_i[N-2:0], fb};

endmodule

// File: rtl/otp_stream_cipher.sv
// ----------------------------------------------------------------------------
// otp_stream_cipher
// Streaming one-time-pad XOR cipher. Each accepted M-bit beat is XORed with
// the current N-bit key replicated to M bits; the key then advances one LFSR
// step. A key may be used for MAX_BEATS beats, after which input is held off
// until a new key is loaded. Encrypt and decrypt are the same operation.
//
// Build option: define OTP_LFSR_EN to advance the key on every accepted beat;
// leave it undefined for a static, repeated-key pad.
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   key_load        single-cycle pulse loading key_seed (zero seed -> NOKEY)
//   key_seed [N]    new key value
//   bus (slave)     in_valid/in_ready/in_data, out_valid/out_ready/out_data
//   key_active      state is ACTIVE
//   key_exhausted   state is EXHAUSTED
//   beat_count [CW] beats accepted since the last key load
// ----------------------------------------------------------------------------
module otp_stream_cipher
  import otp_pkg::*;
#(
  parameter int           M         = 8,
  parameter int           N         = 8,
  parameter logic [N-1:0] TAPS      = N'(OTP_DEFAULT_TAPS),
  parameter int           MAX_BEATS = 256,
  parameter int           CW        = $clog2(MAX_BEATS + 1)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                key_load,
  input  logic [N-1:0]        key_seed,
  otp_stream_cipher_if.slave  bus,
  output logic                key_active,
  output logic                key_exhausted,
  output logic [CW-1:0]       beat_count
);

`ifdef OTP_LFSR_EN
  localparam bit LFSR_EN = 1'b1;
`else
  localparam bit LFSR_EN = 1'b0;
`endif

  otp_state_e    state_q;
  logic          key_active_q;
  logic          key_exhausted_q;
  logic [N-1:0]  key_q;
  logic [CW-1:0] count_q;
  logic          out_valid_q;
  logic [M-1:0]  out_data_q;

  logic          in_ready;
  logic          accept;
  logic          last_beat;
  logic          seed_zero;
  logic [M-1:0]  pad;
  logic [N-1:0]  key_step;
  logic [N-1:0]  key_adv;

  // Pad bit i is key bit (i mod N), so short keys repeat across wide beats.
  for (genvar i = 0; i < M; i++) begin : g_pad
    assign pad[i] = key_q[i % N];
  end

  otp_lfsr_step #(
    .N    (N),
    .TAPS (TAPS)
  ) u_lfsr_step (
    .key_i      (key_q),
    .key_next_o (key_step)
  );

  assign key_adv = LFSR_EN ? key_step : key_q;

  // A key load in the same cycle wins over the beat; the beat stays pending
  // at the source and is re-presented under the new key.
  assign in_ready  = (state_q == ACTIVE) && !key_load && (!out_valid_q || bus.out_ready);
  assign accept    = bus.in_valid && in_ready;
  assign last_beat = (count_q == CW'(MAX_BEATS - 1));
  assign seed_zero = (key_seed == '0);

  // Key lifecycle FSM; status outputs are registered alongside the state.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= NOKEY;
      key_active_q    <= 1'b0;
      key_exhausted_q <= 1'b0;
    end else if (key_load) begin
      // A zero seed would lock the LFSR at zero, so it disables the cipher.
      state_q         <= seed_zero ? NOKEY : ACTIVE;
      key_active_q    <= !seed_zero;
      key_exhausted_q <= 1'b0;
    end else if (accept && last_beat) begin
      state_q         <= EXHAUSTED;
      key_active_q    <= 1'b0;
      key_exhausted_q <= 1'b1;
    end
  end

  // Key register and beat counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      key_q   <= '0;
      count_q <= '0;
    end else if (key_load) begin
      key_q   <= key_seed;
      count_q <= '0;
    end else if (accept) begin
      key_q   <= key_adv;
      count_q <= count_q + CW'(1);
    end
  end

  // Output register. A pending result is unaffected by key_load: it was
  // already computed under the old pad and drains normally.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else if (accept) begin
      out_valid_q <= 1'b1;
      out_data_q  <= bus.in_data ^ pad;
    end else if (bus.out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  assign bus.in_ready   = in_ready;
  assign bus.out_valid  = out_valid_q;
  assign bus.out_data   = out_data_q;
  assign key_active     = key_active_q;
  assign key_exhausted  = key_exhausted_q;
  assign beat_count     = count_q;

endmodule

// File: doc/otp_stream_cipher.md
# otp_stream_cipher

Streaming one-time-pad XOR cipher with a per-beat evolving key and a hard key-use limit. Accepts M-bit data beats over a valid/ready handshake and XORs each beat with the current key, replicated to M bits. The key then advances one LFSR step, so consecutive beats use different pads. Encryption and decryption are the same operation, so one instance serves both ends of the link.

## Interface
- `M`, 8: data beat width in bits.
- `N`, 8: key register width in bits; N ≥ 2.
- `TAPS`, 8'hB8: LFSR tap mask, N bits wide. The default is maximal-length for N=8.
- `MAX_BEATS`, 256: beats allowed per loaded key before it is exhausted; ≥ 1.
- `CW`, $clog2(MAX_BEATS+1): derived, width of the beat counter; do not override.

- `clk` in 1: the single clock, rising edge.
- `rst` in 1: synchronous reset, active-high.
- `key_load` in 1: single-cycle pulse that loads `key_seed`.
- `key_seed` in N: new key value.
- `in_valid` in 1: input beat valid.
- `in_data` in M: plaintext or ciphertext beat.
- `in_ready` out 1: block can accept a beat this cycle.
- `out_valid` out 1: output register holds a result.
- `out_data` out M: `in_data` XOR expanded key.
- `out_ready` in 1: downstream accepts `out_data`.
- `key_active` out 1: state is ACTIVE.
- `key_exhausted` out 1: state is EXHAUSTED.
- `beat_count` out CW: beats accepted since the last key load.

## Operation
- Expanded key: bit i of the M-bit pad is K[i % N], where K is the current key register.
- A beat is accepted when `in_valid && in_ready`. On acceptance:
  - `out_data` ← `in_data ^ pad(K)`.
  - `out_valid` ← 1.
  - K ← lfsr_step(K).
  - `beat_count` ← `beat_count` + 1.
- LFSR step is Fibonacci: `fb = ^(K & TAPS)`, K_next = {K[N-2:0], fb}.
- State machine, 2-bit encoding:
  - NOKEY → ACTIVE on `key_load` with a nonzero seed.
  - ACTIVE → EXHAUSTED on the acceptance that brings `beat_count` to MAX_BEATS.
  - ACTIVE or EXHAUSTED → ACTIVE on `key_load` with a nonzero seed.
  - Any state → NOKEY on `key_load` with a zero seed. A zero seed would lock the LFSR.
- Every `key_load` sets K ← `key_seed` and `beat_count` ← 0.
- `in_ready = (state==ACTIVE) && !key_load && (!out_valid || out_ready)`. Key load wins over a simultaneous beat; that beat is not accepted.
- Output register: `out_valid` clears on `out_ready` when no new beat is accepted in the same cycle. Simultaneous drain and accept replaces the contents, `out_valid` stays 1.
- `key_load` does not disturb a pending output; it drains normally under the old pad.
- Beats presented in NOKEY or EXHAUSTED are held off (`in_ready`=0), never dropped and never passed in clear.

## Timing
- Reset values: state NOKEY, K=0, `beat_count`=0, `out_valid`=0, `out_data`=0, `in_ready`=0, `key_active`=0, `key_exhausted`=0.
- Latency is 1 cycle: a beat accepted at edge t shows `out_valid`=1 after edge t.
- Throughput is one beat per cycle while `out_ready`=1.
- `key_load` at edge t: `key_active`=1 and `in_ready` can be 1 from cycle t+1.
- Exhaustion: the MAX_BEATS-th acceptance sets `key_exhausted`=1 in the next cycle; `in_ready` is 0 from then on.
- Reset mid-operation discards the pending output and the key.

## Configuration
- `OTP_LFSR_EN` defined: K advances via the LFSR on every accepted beat, as described above.
- `OTP_LFSR_EN` undefined: K is static after load, giving a pure repeated-key pad. Beat counting and exhaustion are unchanged.

## Structure
- Package `otp_pkg` holds:
  - State encodings NOKEY=2'd0, ACTIVE=2'd1, EXHAUSTED=2'd2.
  - The default tap constant 8'hB8.
- Sub-module `otp_lfsr_step`, parameters N and TAPS, purely combinational: K in, K_next out. It is reused by the future keystream generator.

## Test plan
All scenarios use defaults unless noted.
- Reset, then `in_valid`=1 → `in_ready`=0, `out_valid`=0, all outputs 0.
- Load seed 8'h01, send 8'hA5 then 8'h00 with `out_ready`=1 → `out_data` 8'hA4 then 8'h02 (`OTP_LFSR_EN` defined).
- Round trip: encrypt 8'h3C, 8'hC3, 8'hFF under seed 8'h5A, reload 8'h5A, feed the ciphertexts back → outputs 8'h3C, 8'hC3, 8'hFF.
- MAX_BEATS=4, four beats accepted → `key_exhausted`=1, `beat_count`=4, fifth beat stalls. `key_load` 8'h77 → ACTIVE, `beat_count`=0.
- `out_ready`=0 for 3 cycles with `in_valid`=1 → one beat held, `in_ready`=0, no loss. Release → stream resumes in order.
- `key_load` with `key_seed`=0 while ACTIVE and `in_valid`=1 → beat not accepted, state NOKEY. M=12, N=8, seed 8'h81, data 12'h000 → `out_data` 12'h181.
